salu_issue_arbiter: RTL and testbench

- Issue-stage block directly downstream of the SPR dependency table.
- Combines the per-wavefront SPR ready vector with instruction-buffer SALU-valid bits and an outstanding-instruction mask.
- Selects one wavefront per cycle using round-robin and issues it to the SALU.
- Returns the issued wavefront's VCC/SCC/EXEC/M0 write flags, which the dependency table uses to set its busy bits.

---
 rtl/salu_issue_arbiter_pkg.sv | 24 ++
 rtl/salu_issue_arbiter_if.sv | 43 ++++
 rtl/salu_issue_arbiter_rr_arbiter_40.sv | 35 +++
 rtl/salu_issue_arbiter.sv | 84 ++++++++
 tb/tb_salu_issue_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/salu_issue_arbiter_pkg.sv
// Shared SALU issue constants, the SPR write-flag record and the enabled wavefront-ID decoder.
package salu_issue_arbiter_pkg;

  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;

  typedef struct packed {
    logic m0;
    logic exec;
    logic scc;
    logic vcc;
  } spr_flags_t;

  // IDs 40..63 match no slot, so they decode to zero
  function automatic logic [WF_PER_CU-1:0] wf_decode(input logic en,
                                                      input logic [WF_ID_LENGTH-1:0] id);
    logic [WF_PER_CU-1:0] dec;
    dec = '0;
    for (int i = 0; i < WF_PER_CU; i++)
      dec[i] = en && (id == WF_ID_LENGTH'(i));
    return dec;
  endfunction

endpackage

// File: rtl/salu_issue_arbiter_if.sv
// Issue-stage bundle: dependency/decode/retire inputs and the registered SALU grant.
interface salu_issue_arbiter_if;
  import salu_issue_arbiter_pkg::*;

  logic [WF_PER_CU-1:0]    ready_arry_spr;
  logic [WF_PER_CU-1:0]    salu_valid_arry;
  logic                    salu_ready;
  logic                    f_decode_valid;
  logic [WF_ID_LENGTH-1:0] f_decode_wfid;
  logic                    f_decode_vcc_wr;
  logic                    f_decode_scc_wr;
  logic                    f_decode_exec_wr;
  logic                    f_decode_m0_wr;
  logic                    f_salu_done_valid;
  logic [WF_ID_LENGTH-1:0] f_salu_done_wfid;
  logic                    f_flush_en;
  logic [WF_ID_LENGTH-1:0] f_flush_wfid;
  logic                    issued_valid;
  logic [WF_ID_LENGTH-1:0] issued_wfid;
  logic                    issue_alu_vcc_wr;
  logic                    issue_alu_scc_wr;
  logic                    issue_alu_exec_wr;
  logic                    issue_alu_m0_wr;
  logic [WF_PER_CU-1:0]    pending_arry;

  modport master (
    output ready_arry_spr, salu_valid_arry, salu_ready,
           f_decode_valid, f_decode_wfid, f_decode_vcc_wr, f_decode_scc_wr,
           f_decode_exec_wr, f_decode_m0_wr, f_salu_done_valid, f_salu_done_wfid,
           f_flush_en, f_flush_wfid,
    input  issued_valid, issued_wfid, issue_alu_vcc_wr, issue_alu_scc_wr,
           issue_alu_exec_wr, issue_alu_m0_wr, pending_arry
  );

  modport slave (
    input  ready_arry_spr, salu_valid_arry, salu_ready,
           f_decode_valid, f_decode_wfid, f_decode_vcc_wr, f_decode_scc_wr,
           f_decode_exec_wr, f_decode_m0_wr, f_salu_done_valid, f_salu_done_wfid,
           f_flush_en, f_flush_wfid,
    output issued_valid, issued_wfid, issue_alu_vcc_wr, issue_alu_scc_wr,
           issue_alu_exec_wr, issue_alu_m0_wr, pending_arry
  );
endinterface

// File: rtl/salu_issue_arbiter_rr_arbiter_40.sv
// Round-robin pick: first request strictly above i_ptr, wrapping at WF_PER_CU, returned as an ID.
module rr_arbiter_40
  import salu_issue_arbiter_pkg::*;
(
  input  logic [WF_PER_CU-1:0]    i_req,
  input  logic [WF_ID_LENGTH-1:0] i_ptr,
  output logic                    o_found,
  output logic [WF_ID_LENGTH-1:0] o_id
);
  localparam int IW = WF_ID_LENGTH + 1;

  logic [WF_PER_CU-1:0] w_onehot;
  logic [IW-1:0]        w_idx;

  // i runs 1..WF_PER_CU so the pointer slot itself is visited last
  always_comb begin
    w_onehot = '0;
    w_idx    = '0;
    for (int i = 1; i <= WF_PER_CU; i++) begin
      w_idx = {1'b0, i_ptr} + IW'(i);
      if (w_idx >= IW'(WF_PER_CU))
        w_idx = w_idx - IW'(WF_PER_CU);
      if ((w_onehot == '0) && i_req[w_idx[WF_ID_LENGTH-1:0]])
        w_onehot[w_idx[WF_ID_LENGTH-1:0]] = 1'b1;
    end
  end

  always_comb begin
    o_id = '0;
    for (int i = 0; i < WF_PER_CU; i++)
      if (w_onehot[i]) o_id = o_id | WF_ID_LENGTH'(i);
  end

  assign o_found = |w_onehot;
endmodule

// File: rtl/salu_issue_arbiter.sv
// SALU issue arbiter: masks SPR-ready wavefronts by pending/flush, picks one round-robin,
// and returns that wavefront's decoded SPR write flags alongside the grant.
module salu_issue_arbiter
  import salu_issue_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  salu_issue_arbiter_if.slave  bus
);
  logic [WF_PER_CU-1:0]               r_pending;
  spr_flags_t [WF_PER_CU-1:0]         r_flags;
  logic [WF_ID_LENGTH-1:0]            r_ptr;
  logic                               r_iss_valid;
  logic [WF_ID_LENGTH-1:0]            r_iss_wfid;
  spr_flags_t                         r_iss_flags;

  logic [WF_PER_CU-1:0]    w_flush_mask, w_done_mask, w_dec_mask, w_cand, w_gnt_mask;
  logic [WF_ID_LENGTH-1:0] w_gnt_id;
  logic                    w_found, w_grant;
  spr_flags_t              w_dec_flags;

  assign w_flush_mask = wf_decode(bus.f_flush_en,        bus.f_flush_wfid);
  assign w_done_mask  = wf_decode(bus.f_salu_done_valid, bus.f_salu_done_wfid);
  assign w_dec_mask   = wf_decode(bus.f_decode_valid,    bus.f_decode_wfid);
  assign w_dec_flags  = {bus.f_decode_m0_wr, bus.f_decode_exec_wr,
                         bus.f_decode_scc_wr, bus.f_decode_vcc_wr};

  assign w_cand = bus.ready_arry_spr & bus.salu_valid_arry & ~r_pending & ~w_flush_mask;

  rr_arbiter_40 u_rr (
    .i_req   (w_cand),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_id    (w_gnt_id)
  );

  assign w_grant    = bus.salu_ready && w_found;
  assign w_gnt_mask = wf_decode(w_grant, w_gnt_id);

  // Grant never targets a pending or flushed slot, so set and clear never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_ptr     <= WF_ID_LENGTH'(WF_PER_CU - 1);
    end else begin
      r_pending <= (r_pending & ~w_done_mask & ~w_flush_mask) | w_gnt_mask;
      if (w_grant) r_ptr <= w_gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
    end else begin
      for (int i = 0; i < WF_PER_CU; i++) begin
        if (w_flush_mask[i])    r_flags[i] <= '0;
        else if (w_dec_mask[i]) r_flags[i] <= w_dec_flags;
      end
    end
  end

  // Reads the entry before any same-cycle decode write lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_valid <= 1'b0;
      r_iss_wfid  <= '0;
      r_iss_flags <= '0;
    end else begin
      r_iss_valid <= w_grant;
      if (w_grant) begin
        r_iss_wfid  <= w_gnt_id;
        r_iss_flags <= r_flags[w_gnt_id];
      end
    end
  end

  assign bus.issued_valid      = r_iss_valid;
  assign bus.issued_wfid       = r_iss_wfid;
  assign bus.issue_alu_vcc_wr  = r_iss_flags.vcc;
  assign bus.issue_alu_scc_wr  = r_iss_flags.scc;
  assign bus.issue_alu_exec_wr = r_iss_flags.exec;
  assign bus.issue_alu_m0_wr   = r_iss_flags.m0;
  assign bus.pending_arry      = r_pending;
endmodule

// File: tb/tb_salu_issue_arbiter.sv
// Directed bench for salu_issue_arbiter: expected grants queued at stimulus time, popped by a monitor.
module tb_salu_issue_arbiter;
  import salu_issue_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // {wfid, m0, exec, scc, vcc}
  logic [WF_ID_LENGTH+3:0] exp_q[$];

  salu_issue_arbiter_if sif ();

  salu_issue_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && sif.issued_valid) begin
      logic [WF_ID_LENGTH+3:0] act, e;
      act = {sif.issued_wfid, sif.issue_alu_m0_wr, sif.issue_alu_exec_wr,
             sif.issue_alu_scc_wr, sif.issue_alu_vcc_wr};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got wfid=%0d flags=%b, expected no issue",
                 act[WF_ID_LENGTH+3:4], act[3:0]);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL issue: got wfid=%0d flags=%b, expected wfid=%0d flags=%b",
                   act[WF_ID_LENGTH+3:4], act[3:0], e[WF_ID_LENGTH+3:4], e[3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int id, input logic [3:0] fl);
    exp_q.push_back({WF_ID_LENGTH'(id), fl});
    tick();
  endtask

  task automatic clear_inputs();
    sif.ready_arry_spr    = '1;
    sif.salu_valid_arry   = '0;
    sif.salu_ready        = 1'b1;
    sif.f_decode_valid    = 1'b0;
    sif.f_decode_wfid     = '0;
    {sif.f_decode_m0_wr, sif.f_decode_exec_wr, sif.f_decode_scc_wr, sif.f_decode_vcc_wr} = 4'b0;
    sif.f_salu_done_valid = 1'b0;
    sif.f_salu_done_wfid  = '0;
    sif.f_flush_en        = 1'b0;
    sif.f_flush_wfid      = '0;
  endtask

  task automatic decode(input int id, input logic [3:0] fl);
    sif.f_decode_valid = 1'b1;
    sif.f_decode_wfid  = WF_ID_LENGTH'(id);
    {sif.f_decode_m0_wr, sif.f_decode_exec_wr, sif.f_decode_scc_wr, sif.f_decode_vcc_wr} = fl;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [WF_PER_CU-1:0] bit_of(input int id);
    logic [WF_PER_CU-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  initial begin
    // Reset held with every wavefront eligible
    clear_inputs();
    sif.salu_valid_arry = '1;
    tick();
    tick();
    chk("rst_issued_valid", 64'(sif.issued_valid), 64'd0);
    chk("rst_issued_wfid",  64'(sif.issued_wfid),  64'd0);
    chk("rst_flags", 64'({sif.issue_alu_m0_wr, sif.issue_alu_exec_wr,
                          sif.issue_alu_scc_wr, sif.issue_alu_vcc_wr}), 64'd0);
    chk("rst_pending", 64'(sif.pending_arry), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) expect_grant(i, 4'b0000);
    chk("seq_pending", 64'(sif.pending_arry), 64'h3FF);
    sif.salu_valid_arry = '0;
    tick();

    // Wrap 39 -> 0 from pointer 38; done(38) alongside the grant of 39
    do_reset();
    sif.salu_valid_arry = bit_of(38);
    expect_grant(38, 4'b0000);
    sif.salu_valid_arry   = bit_of(39) | bit_of(0);
    sif.f_salu_done_valid = 1'b1;
    sif.f_salu_done_wfid  = 6'd38;
    expect_grant(39, 4'b0000);
    sif.f_salu_done_valid = 1'b0;
    expect_grant(0, 4'b0000);
    sif.salu_valid_arry = '0;
    chk("wrap_pending", 64'(sif.pending_arry), 64'(bit_of(39) | bit_of(0)));

    // Flag return, including decode-write racing a grant of the same wavefront
    decode(5, 4'b0011);
    tick();
    decode(6, 4'b0100);
    tick();
    decode(6, 4'b1000);
    sif.salu_valid_arry = bit_of(6);
    expect_grant(6, 4'b0100);
    sif.f_decode_valid  = 1'b0;
    sif.salu_valid_arry = bit_of(5);
    expect_grant(5, 4'b0011);
    sif.salu_valid_arry   = bit_of(6);
    sif.f_salu_done_valid = 1'b1;
    sif.f_salu_done_wfid  = 6'd6;
    tick();
    sif.f_salu_done_valid = 1'b0;
    expect_grant(6, 4'b1000);
    sif.salu_valid_arry = '0;
    tick();

    // Stall keeps the pointer at 5, so 10 wins over 2 afterwards
    do_reset();
    sif.salu_valid_arry = bit_of(5);
    expect_grant(5, 4'b0000);
    sif.salu_valid_arry = bit_of(2) | bit_of(10);
    sif.salu_ready      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_issue", 64'(sif.issued_valid), 64'd0);
    end
    sif.salu_ready = 1'b1;
    expect_grant(10, 4'b0000);
    expect_grant(2, 4'b0000);
    sif.salu_valid_arry = '0;
    tick();

    // Re-issue only after done has been sampled
    do_reset();
    sif.salu_valid_arry = bit_of(7);
    expect_grant(7, 4'b0000);
    sif.f_salu_done_valid = 1'b1;
    sif.f_salu_done_wfid  = 6'd7;
    tick();
    chk("done_same_cycle_no_issue", 64'(sif.issued_valid), 64'd0);
    chk("done_pending_clear", 64'(sif.pending_arry), 64'd0);
    sif.f_salu_done_valid = 1'b0;
    expect_grant(7, 4'b0000);
    sif.salu_valid_arry = '0;
    tick();

    // Flush beats decode; out-of-range flush ID affects nothing
    do_reset();
    decode(3, 4'b1111);
    tick();
    sif.salu_valid_arry = bit_of(3);
    sif.f_flush_en      = 1'b1;
    sif.f_flush_wfid    = 6'd3;
    tick();
    chk("flush_no_issue", 64'(sif.issued_valid), 64'd0);
    chk("flush_pending", 64'(sif.pending_arry), 64'd0);
    sif.f_decode_valid = 1'b0;
    sif.f_flush_wfid   = 6'd43;
    expect_grant(3, 4'b0000);
    chk("oor_flush_pending", 64'(sif.pending_arry), 64'(bit_of(3)));
    sif.f_flush_en      = 1'b0;
    sif.salu_valid_arry = '0;
    tick();
    tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
